kd_tree_host: RTL
=================

# kd_tree_host

Command initiator for the kd-tree root. Buffers up to MAX_CENTERS centers from the system side, then drives the root node's top command/data port through reset, center fill, axis configuration and sort start, and reports the settled root center. Sits between the system/SW interface and the top port of the root `node`. It is the only source of `command_from_top` for the root.

## Interface
- `MAX_CENTERS`, 16: center buffer depth (power of two).
- `DATA_W`, 24: data word width (3 × 8-bit coordinates).
- `CMD_W`, 5: command width.
- `TIMEOUT`, 4096: max cycles waiting on any single root response.
- `clk`  in  1  clock.
- `rst`  in  1  reset.
- Reset and clocking (already decided): one clock; reset is asynchronous and active-high.
- `load_valid`  in  1  center write strobe.
- `load_data`  in  DATA_W  center value.
- `load_ready`  out  1  buffer can accept (not full, IDLE).
- `start`  in  1  begin run (1-cycle pulse).
- `axis_in`  in  2  initial sort axis.
- `command_to_root`  out  CMD_W  to root `command_from_top`.
- `data_to_root`  out  DATA_W  to root `data_from_top`.
- `command_from_root`  in  CMD_W  root `command_to_top`.
- `data_from_root`  in  DATA_W  root `data_to_top`.
- `busy`  out  1  run in progress.
- `done`  out  1  1-cycle pulse, run finished.
- `error`  out  1  sticky timeout/empty flag.
- `result_center`  out  DATA_W  root center captured at `valid_sort`.
- `count`  out  $clog2(MAX_CENTERS)+1  centers buffered.

## Operation
- Codes: nop 00, rst 1f, rst_done 1e, center_fill 01, configure_sort_axis 02, center_fill_done 05, configure_sort_axis_done 07, start_sorting 09, ready_to_sort 0a, valid_sort 0f.
- Load, IDLE only: `load_valid && load_ready` writes `buf[count]`, `count++`. At count==MAX_CENTERS, `load_ready`=0; extra writes dropped.
- States: IDLE → RST → FILL → AXIS → SORT_GO → SORT_WAIT → DONE → IDLE; any waiting state → ERR on timeout.
- IDLE: drive nop/0. On `start`: count==0 → ERR; else clear `error`, go RST.
- RST: drive rst, data 0, until `command_from_root==rst_done`, then FILL with `rd_ptr`=0.
- FILL: drive center_fill, `data_to_root=buf[rd_ptr]`. `rd_ptr++` each cycle, saturating at count-1 (last center re-presented). On center_fill_done → AXIS.
- AXIS: drive configure_sort_axis, data = zero-extended `axis_in` latched at start. On configure_sort_axis_done → SORT_GO.
- SORT_GO: drive start_sorting with the same data. On ready_to_sort → SORT_WAIT.
- SORT_WAIT: drive nop. On `valid_sort`: capture `data_from_root` into `result_center` → DONE.
- DONE: `done`=1 for one cycle, count←0, → IDLE.
- ERR: drive nop, `error`=1, count←0, → IDLE next cycle. `error` stays set until the next accepted `start` or `rst`.
- Watchdog: cleared on each state entry, incremented in every waiting state. Reaching TIMEOUT-1 → ERR.
- `start` while busy: ignored. Unrecognized root codes: ignored.

## Timing
- Reset values: all outputs 0 except `load_ready`=1. Command nop, state IDLE, count 0, `result_center` 0.
- All outputs are registered. A response sampled at edge n changes the command at edge n+1.
- `start` → `rst` on `command_to_root` at the next edge. `busy` is high from that edge through the DONE cycle.
- Buffer write is visible in `count` one cycle after the handshake.
- Simultaneous `start` and `load_valid` in IDLE: write accepted, run count includes it.
- `rst` mid-run: immediate IDLE, nop, buffer emptied. The root sees nop; a following run re-issues rst.

## Structure
- `kd_tree_pkg`: command localparams, DATA_W, CMD_W, state enum. Shared with `node`.
- Sub-module `center_buffer`: write-port register file with count and a combinational read at `rd_ptr`.
- FSM and watchdog live in top.

## Test plan
- Behavioral 3-node tree model, load 3 centers 0x0a0b0c/0x101010/0x050505, start, axis 0 → sequence rst, center_fill ×≥3, configure_sort_axis, start_sorting. `done` pulses, `result_center` = model's root center.
- Start with count 0 → `error`=1 within 2 cycles, no non-nop command issued.
- Root model never returns rst_done → ERR after TIMEOUT cycles, `error` sticky, next start clears it.
- Load 17 words with MAX_CENTERS=16 → `load_ready` low after 16th, count=16, 17th dropped.
- Assert `rst` during FILL → outputs at reset values same cycle (async), count 0.
- Start during SORT_WAIT → ignored, single `done` pulse.

Source files
------------

// File: rtl/kd_tree_pkg.sv
// Shared kd-tree definitions: root command codes, word widths, host states.
// Imported by the host and by the tree nodes.
package kd_tree_pkg;

  localparam int KD_DATA_W = 24;
  localparam int KD_CMD_W  = 5;

  localparam logic [4:0] CMD_NOP         = 5'h00;
  localparam logic [4:0] CMD_CENTER_FILL = 5'h01;
  localparam logic [4:0] CMD_AXIS        = 5'h02;
  localparam logic [4:0] CMD_FILL_DONE   = 5'h05;
  localparam logic [4:0] CMD_AXIS_DONE   = 5'h07;
  localparam logic [4:0] CMD_START_SORT  = 5'h09;
  localparam logic [4:0] CMD_READY_SORT  = 5'h0a;
  localparam logic [4:0] CMD_VALID_SORT  = 5'h0f;
  localparam logic [4:0] CMD_RST_DONE    = 5'h1e;
  localparam logic [4:0] CMD_RST         = 5'h1f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_FILL,
    S_AXIS,
    S_SORT_GO,
    S_SORT_WAIT,
    S_DONE,
    S_ERR
  } host_state_t;

  function automatic logic is_waiting(host_state_t s);
    return (s == S_RST) || (s == S_FILL) || (s == S_AXIS) ||
           (s == S_SORT_GO) || (s == S_SORT_WAIT);
  endfunction

endpackage

// File: rtl/center_buffer.sv
// Center register file: append-only write port with occupancy count,
// combinational read at an external pointer.
module center_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write,
  input  logic [DATA_W-1:0]          data,
  input  logic                       clear,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full    = count[AW];
  assign push    = write && !full;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[count[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      count <= count + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/kd_tree_host.sv
// Root command initiator: buffers centers, then walks the root node through
// reset, fill, axis setup and sort, and captures the settled root center.
module kd_tree_host
  import kd_tree_pkg::*;
#(
  parameter int MAX_CENTERS = 16,
  parameter int DATA_W      = KD_DATA_W,
  parameter int CMD_W       = KD_CMD_W,
  parameter int TIMEOUT     = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  input  logic [DATA_W-1:0]             load_data,
  output logic                          load_ready,
  input  logic                          start,
  input  logic [1:0]                    axis_in,
  output logic [CMD_W-1:0]              command_to_root,
  output logic [DATA_W-1:0]             data_to_root,
  input  logic [CMD_W-1:0]              command_from_root,
  input  logic [DATA_W-1:0]             data_from_root,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [DATA_W-1:0]             result_center,
  output logic [$clog2(MAX_CENTERS):0]  count
);

  localparam int AW = $clog2(MAX_CENTERS);
  localparam int WW = $clog2(TIMEOUT);

  host_state_t       state, next;
  logic [WW-1:0]     wd;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     last;
  logic [1:0]        axis_q;
  logic [DATA_W-1:0] rd_data;
  logic              wr, clr, full, empty_go, wd_hit;

  assign wr       = load_valid && load_ready;
  assign clr      = (state == S_DONE) || (state == S_ERR);
  // a load in the same cycle as start still counts toward this run
  assign empty_go = (count == '0) && !wr;
  assign wd_hit   = wd == WW'(TIMEOUT - 1);
  assign last     = AW'(count - (AW+1)'(1));

  center_buffer #(
    .DEPTH  (MAX_CENTERS),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .write   (wr),
    .data    (load_data),
    .clear   (clr),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:
        if (start) next = empty_go ? S_ERR : S_RST;
      S_RST:
        if (command_from_root == CMD_W'(CMD_RST_DONE)) next = S_FILL;
        else if (wd_hit) next = S_ERR;
      S_FILL:
        if (command_from_root == CMD_W'(CMD_FILL_DONE)) next = S_AXIS;
        else if (wd_hit) next = S_ERR;
      S_AXIS:
        if (command_from_root == CMD_W'(CMD_AXIS_DONE)) next = S_SORT_GO;
        else if (wd_hit) next = S_ERR;
      S_SORT_GO:
        if (command_from_root == CMD_W'(CMD_READY_SORT)) next = S_SORT_WAIT;
        else if (wd_hit) next = S_ERR;
      S_SORT_WAIT:
        if (command_from_root == CMD_W'(CMD_VALID_SORT)) next = S_DONE;
        else if (wd_hit) next = S_ERR;
      S_DONE, S_ERR:
        next = S_IDLE;
      default:
        next = S_IDLE;
    endcase
  end

  always_comb begin
    command_to_root = CMD_W'(CMD_NOP);
    data_to_root    = '0;
    unique case (state)
      S_RST: command_to_root = CMD_W'(CMD_RST);
      S_FILL: begin
        command_to_root = CMD_W'(CMD_CENTER_FILL);
        data_to_root    = rd_data;
      end
      S_AXIS: begin
        command_to_root = CMD_W'(CMD_AXIS);
        data_to_root    = DATA_W'(axis_q);
      end
      S_SORT_GO: begin
        command_to_root = CMD_W'(CMD_START_SORT);
        data_to_root    = DATA_W'(axis_q);
      end
      default: ;
    endcase
  end

  assign load_ready = (state == S_IDLE) && !full;
  assign busy       = (state != S_IDLE) && (state != S_ERR);
  assign done       = state == S_DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wd            <= '0;
      rd_ptr        <= '0;
      axis_q        <= '0;
      error         <= 1'b0;
      result_center <= '0;
    end else begin
      state <= next;
      if (next != state || !is_waiting(state)) wd <= '0;
      else wd <= wd + WW'(1);
      // last center is re-presented until the root reports fill done
      if (state != S_FILL) rd_ptr <= '0;
      else if (rd_ptr != last) rd_ptr <= rd_ptr + AW'(1);
      if (state == S_IDLE && start) axis_q <= axis_in;
      if (next == S_ERR) error <= 1'b1;
      else if (state == S_IDLE && start) error <= 1'b0;
      if (state == S_SORT_WAIT &&
          command_from_root == CMD_W'(CMD_VALID_SORT))
        result_center <= data_from_root;
    end
  end

endmodule
